// File: rtl/ctrl_pipe.sv
// ctrl_pipe: WISC decode into a control bundle, carried through STAGES stage registers,
// with RAW/load-use stall, branch flush and HALT drain. Optional macro: CTRL_PIPE_FWD_EN.
module ctrl_pipe #(
  parameter int STAGES = 3,
  parameter int REG_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_op,
  input  logic [1:0]       id_func,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [1:0]       id_src_used,
  input  logic             flush,
  output logic             id_stall,
  output logic [13:0]      ex_ctrl,
  output logic [1:0]       mem_ctrl,
  output logic [4:0]       wb_ctrl,
  output logic             wb_diff_lo,
  output logic [REG_W-1:0] wb_reg,
  output logic             halt
);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam int         CNT_W   = $clog2(STAGES + 1);

`ifdef CTRL_PIPE_FWD_EN
  localparam int HAZ_LAST  = 1;
  localparam bit LOAD_ONLY = 1'b1;
`else
  localparam int HAZ_LAST  = STAGES - 1;
  localparam bit LOAD_ONLY = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alusrc, inv_a, inv_b;
    logic [1:0] bypass_sel, b_op;
    logic       branch, jump, di_sel, i_sel_hi;
    logic       mem_en, mem_wr;
    logic       rf_we;
    logic [1:0] memreg;
    logic       compare;
    logic [1:0] diff_op;
    logic       is_load;
  } ctrl_t;

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [REG_W-1:0] wr_reg;
  } stage_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] drain_cnt, cnt_nxt;
  ctrl_t            dec;
  stage_t           pipe [1:STAGES];
  logic             hazard, capture;

  always_comb begin
    // NOTE: every field gets a default before the case, so no path leaves a latch behind.
    dec        = '0;
    dec.alu_op = 3'b100;
    dec.memreg = 2'b11;
    dec.rf_we  = 1'b1;
    casez (id_op)
      5'b0100?: begin dec.alu_op = {1'b1, id_op[1:0]}; dec.inv_a = id_op[0]; dec.alusrc = 1'b1; end
      5'b0101?: dec.alusrc = 1'b1;
      5'b101??: begin dec.alu_op = {1'b0, ~id_op[0], id_op[1]}; dec.alusrc = 1'b1; end
      5'b10000: begin dec.alusrc = 1'b1; dec.mem_en = 1'b1; dec.mem_wr = 1'b1; dec.rf_we = 1'b0; end
      5'b10001: begin dec.alusrc = 1'b1; dec.mem_en = 1'b1; dec.memreg = 2'b00; dec.is_load = 1'b1; end
      5'b10011: begin dec.alusrc = 1'b1; dec.mem_en = 1'b1; dec.mem_wr = 1'b1; end
      5'b10010: dec.bypass_sel = 2'b11;
      5'b11000: dec.memreg = 2'b01;
      5'b11001: dec.bypass_sel = 2'b01;
      5'b11011: begin
        dec.alu_op = {1'b1, id_func};
        dec.inv_a  = (id_func == 2'b01);
        dec.inv_b  = (id_func == 2'b11);
      end
      5'b11010: dec.alu_op = {1'b0, id_func};
      5'b111??: begin dec.compare = 1'b1; dec.diff_op = id_op[1:0]; dec.inv_a = ~(id_op[1] & id_op[0]); end
      5'b011??: begin dec.branch = 1'b1; dec.b_op = id_op[1:0]; dec.di_sel = 1'b1; dec.rf_we = 1'b0; end
      5'b001??: begin dec.jump = 1'b1; dec.di_sel = id_op[0]; dec.rf_we = id_op[1]; dec.memreg = 2'b10; end
      default:  dec = '0;  // HALT, NOP and undefined opcodes
    endcase
  end

  // A source matches a pending writer in the window; with forwarding only a load in EX counts.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= HAZ_LAST; k++) begin
      if (pipe[k].valid && pipe[k].ctrl.rf_we && (!LOAD_ONLY || pipe[k].ctrl.is_load) &&
          ((id_src_used[0] && id_src1 == pipe[k].wr_reg) ||
           (id_src_used[1] && id_src2 == pipe[k].wr_reg)))
        hazard = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = drain_cnt;
    id_stall  = 1'b1;
    unique case (state)
      RUN: begin
        id_stall = id_valid && hazard && !flush;
        if (id_valid && !id_stall && !flush && id_op == OP_HALT) begin
          state_nxt = DRAIN;
          cnt_nxt   = CNT_W'(STAGES);
        end
      end
      DRAIN: begin
        id_stall = !flush;
        if (flush) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (drain_cnt == CNT_W'(1)) begin
          state_nxt = HALTED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = drain_cnt - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign capture = (state == RUN) && id_valid && !id_stall && !flush && (id_op != OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      // NOTE: the stage registers are reset as a whole so a stale wr_reg can never raise a stall.
      for (int k = 1; k <= STAGES; k++) pipe[k] <= '0;
    end else begin
      // NOTE: non-blocking so every stage shifts from the pre-edge value of its predecessor.
      state     <= state_nxt;
      drain_cnt <= cnt_nxt;
      pipe[1]   <= capture ? '{valid: 1'b1, ctrl: dec, wr_reg: id_wr_reg} : '0;
      for (int k = 2; k <= STAGES; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_comb begin
    ex_ctrl    = '0;
    mem_ctrl   = '0;
    wb_ctrl    = '0;
    wb_diff_lo = 1'b0;
    wb_reg     = '0;
    if (pipe[1].valid)
      ex_ctrl = {pipe[1].ctrl.alu_op, pipe[1].ctrl.alusrc, pipe[1].ctrl.inv_a, pipe[1].ctrl.inv_b,
                 pipe[1].ctrl.bypass_sel, pipe[1].ctrl.b_op, pipe[1].ctrl.branch,
                 pipe[1].ctrl.jump, pipe[1].ctrl.di_sel, pipe[1].ctrl.i_sel_hi};
    if (pipe[2].valid)
      mem_ctrl = {pipe[2].ctrl.mem_en, pipe[2].ctrl.mem_wr};
    if (pipe[STAGES].valid) begin
      wb_ctrl    = {pipe[STAGES].ctrl.rf_we, pipe[STAGES].ctrl.memreg,
                    pipe[STAGES].ctrl.compare, pipe[STAGES].ctrl.diff_op[1]};
      wb_diff_lo = pipe[STAGES].ctrl.diff_op[0];
      wb_reg     = pipe[STAGES].wr_reg;
    end
  end

  assign halt = (state == HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe (STAGES = 3): decode sweep, stalls, flush and HALT sequencing.
module tb_ctrl_pipe;

  localparam int STAGES = 3;
  localparam int NV     = 18;

  logic        clk, rst_n, id_valid, flush;
  logic [4:0]  id_op;
  logic [1:0]  id_func, id_src_used;
  logic [2:0]  id_wr_reg, id_src1, id_src2;
  logic        id_stall, wb_diff_lo, halt;
  logic [13:0] ex_ctrl;
  logic [1:0]  mem_ctrl;
  logic [4:0]  wb_ctrl;
  logic [2:0]  wb_reg;

  int vectors     = 0;
  int miscompares = 0;

  ctrl_pipe #(.STAGES(STAGES), .REG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .id_wr_reg(id_wr_reg), .id_src1(id_src1), .id_src2(id_src2), .id_src_used(id_src_used),
    .flush(flush), .id_stall(id_stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .wb_diff_lo(wb_diff_lo), .wb_reg(wb_reg), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-decoded reference table: opcode, func, ex_ctrl, mem_ctrl, {wb_ctrl, wb_diff_lo}.
  logic [4:0]  t_op  [NV] = '{5'b11011, 5'b01000, 5'b01001, 5'b10001, 5'b10000, 5'b10011,
                              5'b01100, 5'b00110, 5'b11101, 5'b10100, 5'b10010, 5'b00010,
                              5'b11011, 5'b11111, 5'b00101, 5'b11001, 5'b11010, 5'b11000};
  logic [1:0]  t_fn  [NV] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
  logic [13:0] t_ex  [NV] = '{14'b101_0_1_0_00_00_0_0_0_0, 14'b100_1_0_0_00_00_0_0_0_0,
                              14'b101_1_1_0_00_00_0_0_0_0, 14'b100_1_0_0_00_00_0_0_0_0,
                              14'b100_1_0_0_00_00_0_0_0_0, 14'b100_1_0_0_00_00_0_0_0_0,
                              14'b100_0_0_0_00_00_1_0_1_0, 14'b100_0_0_0_00_00_0_1_0_0,
                              14'b100_0_1_0_00_00_0_0_0_0, 14'b010_1_0_0_00_00_0_0_0_0,
                              14'b100_0_0_0_11_00_0_0_0_0, 14'b000_0_0_0_00_00_0_0_0_0,
                              14'b111_0_0_1_00_00_0_0_0_0, 14'b100_0_0_0_00_00_0_0_0_0,
                              14'b100_0_0_0_00_00_0_1_1_0, 14'b100_0_0_0_01_00_0_0_0_0,
                              14'b010_0_0_0_00_00_0_0_0_0, 14'b100_0_0_0_00_00_0_0_0_0};
  logic [1:0]  t_mem [NV] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [5:0]  t_wb  [NV] = '{6'b111000, 6'b111000, 6'b111000, 6'b100000, 6'b011000, 6'b111000,
                              6'b011000, 6'b110000, 6'b111101, 6'b111000, 6'b111000, 6'b000000,
                              6'b111000, 6'b111111, 6'b010000, 6'b111000, 6'b111000, 6'b101000};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] op, input logic [1:0] fn,
                        input logic [2:0] wr, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [1:0] used);
    id_valid = v; id_op = op; id_func = fn; id_wr_reg = wr;
    id_src1 = s1; id_src2 = s2; id_src_used = used;
  endtask

  task automatic idle();
    set_id(1'b0, 5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex"}, ex_ctrl, 0);
    check({tag, "_mem"}, mem_ctrl, 0);
    check({tag, "_wb"}, {wb_ctrl, wb_diff_lo}, 0);
    check({tag, "_wbreg"}, wb_reg, 0);
    check({tag, "_halt"}, halt, 0);
    check({tag, "_stall"}, id_stall, 0);
  endtask

  int exp_stall_len;
  int n;
  int j;

  initial begin
`ifdef CTRL_PIPE_FWD_EN
    exp_stall_len = 1;
`else
    exp_stall_len = STAGES - 1;
`endif
    rst_n = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 5'b11011, 2'b00, 3'd3, 3'd0, 3'd0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    idle();
    rst_n = 1'b1;
    tick();

    // ADD r3 through the pipe.
    set_id(1'b1, 5'b11011, 2'b00, 3'd3, 3'd0, 3'd0, 2'b00);
    tick();
    idle();
    #1;
    check("add_ex", ex_ctrl, 14'b100_0_0_0_00_00_0_0_0_0);
    tick();
    check("add_mem", mem_ctrl, 2'b00);
    check("add_ex_bubble", ex_ctrl, 0);
    tick();
    check("add_wb", wb_ctrl, 5'b11100);
    check("add_wbreg", wb_reg, 3'd3);
    tick();
    check("add_wb_gone", wb_ctrl, 0);

    // Back-to-back decode sweep, each stage compared against its own instruction.
    for (int i = 0; i < NV + STAGES - 1; i++) begin
      if (i < NV) set_id(1'b1, t_op[i], t_fn[i], 3'(i), 3'd0, 3'd0, 2'b00);
      else idle();
      tick();
      check($sformatf("sweep_ex[%0d]", i), ex_ctrl, (i < NV) ? t_ex[i] : 14'd0);
      j = i - 1;
      check($sformatf("sweep_mem[%0d]", i), mem_ctrl, (j >= 0 && j < NV) ? t_mem[j] : 2'd0);
      j = i - (STAGES - 1);
      check($sformatf("sweep_wb[%0d]", i), {wb_ctrl, wb_diff_lo}, (j >= 0 && j < NV) ? t_wb[j] : 6'd0);
    end
    idle();
    repeat (2) tick();

    // LD r2 then ADD reading r2 (through src2).
    set_id(1'b1, 5'b10001, 2'b00, 3'd2, 3'd5, 3'd0, 2'b01);
    #1;
    check("ld_nostall", id_stall, 0);
    tick();
    set_id(1'b1, 5'b11011, 2'b00, 3'd4, 3'd6, 3'd2, 2'b00);
    #1;
    check("unused_src_nostall", id_stall, 0);
    id_src_used = 2'b11;
    #1;
    n = 0;
    while (id_stall && n < 10) begin
      n++;
      tick();
      check("stall_bubble_ex", ex_ctrl, 0);
    end
    check("stall_len", n, exp_stall_len);
    tick();
    check("after_stall_ex", ex_ctrl, 14'b100_0_0_0_00_00_0_0_0_0);
    idle();
    repeat (3) tick();

    // BEQZ in EX redirects while a dependent SUB waits in ID.
    set_id(1'b1, 5'b11011, 2'b00, 3'd6, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 5'b01100, 2'b00, 3'd7, 3'd1, 3'd0, 2'b01);
    tick();
    set_id(1'b1, 5'b11011, 2'b01, 3'd7, 3'd6, 3'd0, 2'b01);
    #1;
    check("pre_flush_stall", id_stall, (exp_stall_len == 1) ? 0 : 1);
    check("branch_in_ex", ex_ctrl, 14'b100_0_0_0_00_00_1_0_1_0);
    flush = 1'b1;
    #1;
    check("flush_stall", id_stall, 0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    check("flush_bubble_ex", ex_ctrl, 0);
    tick();
    check("branch_wb", {wb_ctrl, wb_diff_lo}, 6'b011000);
    tick();
    check("squashed_wb", {wb_ctrl, wb_diff_lo}, 0);
    repeat (2) tick();

    // HALT on the wrong path: flush one cycle into DRAIN.
    set_id(1'b1, 5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    check("halt_id_stall", id_stall, 0);
    tick();
    idle();
    #1;
    check("drain_stall", id_stall, 1);
    check("drain_ex", ex_ctrl, 0);
    tick();
    flush = 1'b1;
    #1;
    check("drain_flush_stall", id_stall, 0);
    tick();
    flush = 1'b0;
    set_id(1'b1, 5'b11011, 2'b00, 3'd1, 3'd0, 3'd0, 2'b00);
    #1;
    check("resume_stall", id_stall, 0);
    tick();
    idle();
    check("resume_ex", ex_ctrl, 14'b100_0_0_0_00_00_0_0_0_0);
    repeat (5) tick();
    check("resume_halt", halt, 0);

    // Reset dropped mid-DRAIN.
    set_id(1'b1, 5'b10001, 2'b00, 3'd3, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    tick();
    idle();
    #1;
    check("pre_rst_mem", mem_ctrl, 2'b10);
    check("pre_rst_stall", id_stall, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_drain_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_halt[%0d]", i), halt, 0);
    end

    // ADD r5 then HALT: ADD retires, halt rises STAGES+1 edges after HALT sits in ID.
    set_id(1'b1, 5'b11011, 2'b00, 3'd5, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    check("halt_accept_stall", id_stall, 0);
    tick();
    set_id(1'b1, 5'b11011, 2'b00, 3'd2, 3'd0, 3'd0, 2'b00);
    #1;
    check("halt_e1_halt", halt, 0);
    check("halt_e1_stall", id_stall, 1);
    check("halt_e1_ex", ex_ctrl, 0);
    tick();
    check("halt_e2_wb", wb_ctrl, 5'b11100);
    check("halt_e2_wbreg", wb_reg, 3'd5);
    check("halt_e2_halt", halt, 0);
    tick();
    check("halt_e3_halt", halt, 0);
    tick();
    check("halt_e4_halt", halt, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("halted_halt[%0d]", i), halt, 1);
      check($sformatf("halted_stall[%0d]", i), id_stall, 1);
      check($sformatf("halted_ex[%0d]", i), ex_ctrl, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 5-stage WISC core. It decodes the 5-bit opcode and 2-bit func of the instruction in decode into a control bundle. It carries each bundle through a parametrised number of stage registers, so every stage reads its own instruction's controls. It also generates load-use/RAW stalls, applies branch flushes, and sequences HALT by draining the pipeline before raising the halt output.

## Interface
Parameters:
- `STAGES`, default 3: stage registers after decode; stage 1 = EX, stage 2 = MEM, stage `STAGES` = WB. Legal values are 3..8.
- `REG_W`, default 3: register index width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: decode holds a real instruction.
- `id_op` in 5: opcode. `id_func` in 2: R-type func.
- `id_wr_reg` in REG_W: destination index, already muxed upstream.
- `id_src1`, `id_src2` in REG_W: source indices.
- `id_src_used` in 2: bit 0 means src1 is read; bit 1 means src2 is read.
- `flush` in 1: the branch or jump in EX resolved as redirecting.
- `id_stall` out 1: freeze PC and the IF/ID register.
- `ex_ctrl` out 14: {alu_op[2:0], alusrc, invA, invB, bypass_sel[1:0], b_op[1:0], branch, jump, di_sel, i_sel_hi}.
- `mem_ctrl` out 2: {mem_en, mem_wr}.
- `wb_ctrl` out 5: {rf_we, memreg[1:0], compare, diff_op_hi}. Bit 0 (diff_op_lo) is packed into `wb_diff_lo`.
- `wb_diff_lo` out 1.
- `wb_reg` out REG_W: write-back index.
- `halt` out 1: the core has halted; sticky until reset.

## Operation
- Decode map:
  - `0100x` ADDI/SUBI: alu_op = {1, op[1:0]}, invA = op[0], alusrc = 1.
  - `0101x` XORI/ANDNI: alusrc = 1.
  - `101xx` rotate/shift-immediate: alu_op = {0, ~op[0], op[1]}, alusrc = 1.
  - `10000` ST: alusrc = 1, mem_en = 1, mem_wr = 1.
  - `10001` LD: alusrc = 1, mem_en = 1, memreg = 00.
  - `10011` STU: alusrc = 1, mem_en = 1, mem_wr = 1, rf_we = 1, memreg = 11.
  - `10010` SLBI: bypass_sel = 11.
  - `11000` LBI: memreg = 01.
  - `11001` BTR: bypass_sel = 01.
  - `11011` R-ALU: alu_op = {1, func}, invA = func == 01, invB = func == 11.
  - `11010` shift-R: alu_op = {0, func}.
  - `111xx` compare: compare = 1, diff_op = op[1:0], invA = ~(op[1] & op[0]).
  - `011xx` branch: branch = 1, b_op = op[1:0], di_sel = 1.
  - `001xx` jump: jump = 1, di_sel = op[0], rf_we = op[1], memreg = 10.
  - `00000` HALT and `00001` NOP: all controls zero.
  - Defaults for every field not listed: alu_op = 100, memreg = 11, rf_we = 1, except ST, branches, HALT, NOP and J/JR, which have rf_we = 0.
  - Undefined opcodes decode as NOP.
- Each stage register holds {valid, bundle, wr_reg, is_load}. Outputs are gated by valid: an invalid stage drives all-zero controls.
- Advance rule: stage k moves to stage k+1 every cycle. Stage 1 captures the decoded instruction when `id_valid & ~id_stall & ~flush & state==RUN`; otherwise it captures a bubble.
- Hazard detection: `id_stall` is asserted when `id_valid` is high and any used source equals `wr_reg` of a valid, rf_we stage in the checked window. The window is set by the macro (see Configuration). Index 0 is not special.
- Flush: the ID instruction is squashed, a bubble enters stage 1, and the branch already in stage 1 proceeds. `flush` overrides the stall, so `id_stall` = 0 during a flush cycle.
- FSM:
  - RUN → DRAIN when a valid, unstalled, unflushed HALT sits in ID. The HALT enters stage 1 as a bubble and `drain_cnt` is loaded with `STAGES`.
  - DRAIN: `id_stall` = 1, stage 1 receives bubbles, and `drain_cnt` decrements. At `drain_cnt` = 1 the FSM goes to HALTED.
  - DRAIN with `flush`: the HALT was wrong-path. The FSM returns to RUN and clears `drain_cnt`.
  - HALTED: `halt` = 1 and `id_stall` = 1. The FSM exits only on reset.

## Timing
- Reset (`rst_n` low, asynchronous): all valids = 0, state = RUN, `drain_cnt` = 0. Every output is 0.
- Decode to `ex_ctrl` is 1 cycle, to `mem_ctrl` 2 cycles, and to `wb_ctrl`/`wb_reg` `STAGES` cycles.
- `id_stall` is combinational from the ID inputs and the stage registers in the same cycle.
- HALT in ID at cycle t gives `halt` = 1 at cycle t + STAGES + 1, provided no flush occurs. Every older instruction's WB completes before `halt` rises.
- Reset asserted mid-DRAIN discards the drain with no halt pulse.

## Configuration
- `CTRL_PIPE_FWD_EN` defined: the core forwards results. The hazard window is stage 1 only, and a stall is raised only when stage 1 `is_load`, i.e. a load-use hazard. Maximum stall is 1 cycle.
- Undefined: there is no forwarding. The hazard window is stages 1..STAGES-1, and the register file is write-before-read in WB. A stall lasts until the writer reaches WB.

## Test plan
- Reset release, then ADD (`11011`, func 00, rd = 3) → cycle 1 `ex_ctrl.alu_op` = 100; cycle `STAGES` `wb_ctrl.rf_we` = 1 with `wb_reg` = 3. All outputs are 0 during reset.
- LD r2 followed by ADD reading r2, with FWD_EN defined → `id_stall` = 1 for exactly 1 cycle. With FWD_EN undefined → `id_stall` high for STAGES-1 = 2 cycles.
- BEQZ in EX with `flush` = 1 while a stalled instruction sits in ID → `id_stall` = 0 and the next `ex_ctrl` is all zero.
- HALT with STAGES = 3 at cycle 10 → `halt` = 1 at cycle 14 and stays high, and `id_stall` stays 1.
- HALT enters DRAIN, then `flush` arrives 1 cycle later → state returns to RUN, `halt` stays 0, and the next instruction decodes normally.
- `rst_n` dropped mid-DRAIN → outputs are 0 immediately and `halt` is never asserted.
